// File: rtl/u409_window_decode.sv
// Registered base/mask window decoder: NWIN AUTOCONFIG windows, decode held from TS to TERM.
// Define DECODE_TIMEOUT_EN to enable the watchdog that ends unclaimed cycles with BERR.
module u409_window_decode #(
   parameter int              NWIN      = 4,
   parameter int              ABITS     = 20,
   parameter logic [NWIN-1:0] LOCK_MASK = NWIN'(4'b0001),
   parameter int              TIMEOUT   = 255
) (
   input  logic             CLK40,
   input  logic             RESET,
   input  logic             TS,
   input  logic             TERM,
   input  logic [ABITS-1:0] A,
   input  logic             RnW,
   input  logic             CFG_WE,
   input  logic [2:0]       CFG_IDX,
   input  logic [ABITS-1:0] CFG_BASE,
   input  logic [ABITS-1:0] CFG_MASK,
   input  logic             CFG_CLR,
   output logic [NWIN-1:0]  HIT,
   output logic [2:0]       HIT_IDX,
   output logic             MISS,
   output logic [NWIN-1:0]  WIN_EN,
   output logic             BUSY,
   output logic             BERR
);

   if (NWIN < 1 || NWIN > 8) begin : g_bad_nwin
      $error("u409_window_decode: NWIN must be 1..8");
   end
   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("u409_window_decode: TIMEOUT must be 1..255");
   end

   typedef enum logic [1:0] {S_IDLE, S_DECODE, S_ACTIVE} state_t;

   state_t           state_reg, state_next;
   logic [ABITS-1:0] a_lat_reg;
   logic             rnw_lat_reg;
   logic [NWIN-1:0]  hit_reg, win_en_reg;
   logic [2:0]       hit_idx_reg;
   logic             miss_reg, berr_reg;

   logic [NWIN-1:0]  match, unlock_vec, hit_next, win_en_next;
   logic [2:0]       hit_idx_next;
   logic             any_hit;
   logic             ts_accept, decode_done, active_done, wd_expire;

   // Per-window registers; match is evaluated against the address latched at TS.
   for (genvar gi = 0; gi < NWIN; gi++) begin : g_win
      logic [ABITS-1:0] base_reg, mask_reg;
      logic             valid_reg, unlock_reg;
      logic             cfg_sel;

      assign cfg_sel = CFG_WE && (CFG_IDX == 3'(gi));

      always_ff @(posedge CLK40) begin
         if (RESET) begin
            base_reg   <= '0;
            mask_reg   <= '0;
            valid_reg  <= 1'b0;
            unlock_reg <= 1'b0;
         end else if (CFG_CLR) begin
            valid_reg  <= 1'b0;
            unlock_reg <= 1'b0;
         end else begin
            if (cfg_sel) begin
               base_reg  <= CFG_BASE;
               mask_reg  <= CFG_MASK;
               valid_reg <= 1'b1;
            end
            if (decode_done && !rnw_lat_reg && hit_next[gi]) begin
               unlock_reg <= 1'b1;
            end
         end
      end

      assign match[gi]      = valid_reg && (((a_lat_reg ^ base_reg) & mask_reg) == '0);
      assign unlock_vec[gi] = unlock_reg;
   end

   // Lowest matching index wins; scanning downward lets lower indices overwrite.
   always_comb begin
      hit_next     = '0;
      hit_idx_next = '0;
      for (int i = NWIN - 1; i >= 0; i--) begin
         if (match[i]) begin
            hit_next     = '0;
            hit_next[i]  = 1'b1;
            hit_idx_next = 3'(i);
         end
      end
   end

   assign any_hit     = |match;
   assign win_en_next = hit_next & (~LOCK_MASK | unlock_vec);

`ifdef DECODE_TIMEOUT_EN
   logic [7:0] wd_cnt_reg;

   always_ff @(posedge CLK40) begin
      if (RESET || state_reg != S_ACTIVE) begin
         wd_cnt_reg <= '0;
      end else if (!TERM) begin
         wd_cnt_reg <= wd_cnt_reg + 8'd1;
      end
   end

   // TERM on the expiry cycle wins, so expiry is qualified by !TERM.
   assign wd_expire = (state_reg == S_ACTIVE) && !TERM && (wd_cnt_reg == 8'(TIMEOUT - 1));
`else
   assign wd_expire = 1'b0;
`endif

   assign ts_accept   = (state_reg == S_IDLE) && TS;
   assign decode_done = (state_reg == S_DECODE) && !TERM;
   assign active_done = (state_reg == S_ACTIVE) && (TERM || wd_expire);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:   if (TS) state_next = S_DECODE;
         S_DECODE: state_next = TERM ? S_IDLE : S_ACTIVE;
         S_ACTIVE: if (TERM || wd_expire) state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK40) begin
      if (RESET) begin
         state_reg   <= S_IDLE;
         a_lat_reg   <= '0;
         rnw_lat_reg <= 1'b1;
         hit_reg     <= '0;
         hit_idx_reg <= '0;
         miss_reg    <= 1'b0;
         win_en_reg  <= '0;
         berr_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         berr_reg  <= wd_expire;
         if (ts_accept) begin
            a_lat_reg   <= A;
            rnw_lat_reg <= RnW;
         end
         if (decode_done) begin
            hit_reg     <= hit_next;
            hit_idx_reg <= hit_idx_next;
            miss_reg    <= ~any_hit;
            win_en_reg  <= win_en_next;
         end else if (active_done) begin
            hit_reg     <= '0;
            hit_idx_reg <= '0;
            miss_reg    <= 1'b0;
            win_en_reg  <= '0;
         end
      end
   end

   assign HIT     = hit_reg;
   assign HIT_IDX = hit_idx_reg;
   assign MISS    = miss_reg;
   assign WIN_EN  = win_en_reg;
   assign BUSY    = (state_reg != S_IDLE);
   assign BERR    = berr_reg;

endmodule

// File: tb/tb_u409_window_decode.sv
// Scoreboard bench for u409_window_decode: expected decodes queued at TS, checked when ACTIVE.
// Watchdog expectations follow DECODE_TIMEOUT_EN.
module tb_u409_window_decode;

   localparam int         NWIN    = 4;
   localparam int         ABITS   = 20;
   localparam int         TIMEOUT = 8;
   localparam logic [3:0] LOCK    = 4'b0001;

   logic             CLK40 = 1'b0;
   logic             RESET = 1'b1;
   logic             TS = 1'b0, TERM = 1'b0, RnW = 1'b1;
   logic [ABITS-1:0] A = '0;
   logic             CFG_WE = 1'b0, CFG_CLR = 1'b0;
   logic [2:0]       CFG_IDX = '0;
   logic [ABITS-1:0] CFG_BASE = '0, CFG_MASK = '0;
   logic [NWIN-1:0]  HIT, WIN_EN;
   logic [2:0]       HIT_IDX;
   logic             MISS, BUSY, BERR;

   u409_window_decode #(
      .NWIN(NWIN), .ABITS(ABITS), .LOCK_MASK(LOCK), .TIMEOUT(TIMEOUT)
   ) dut (
      .CLK40(CLK40), .RESET(RESET), .TS(TS), .TERM(TERM), .A(A), .RnW(RnW),
      .CFG_WE(CFG_WE), .CFG_IDX(CFG_IDX), .CFG_BASE(CFG_BASE), .CFG_MASK(CFG_MASK),
      .CFG_CLR(CFG_CLR), .HIT(HIT), .HIT_IDX(HIT_IDX), .MISS(MISS), .WIN_EN(WIN_EN),
      .BUSY(BUSY), .BERR(BERR)
   );

   always #5 CLK40 = ~CLK40;

   typedef struct packed {
      logic [3:0] hit;
      logic [2:0] idx;
      logic       miss;
      logic [3:0] win_en;
   } exp_t;

   exp_t        sb[$];
   logic [19:0] m_base [NWIN];
   logic [19:0] m_mask [NWIN];
   logic        m_valid [NWIN];
   logic        m_unlock [NWIN];
   int          checks = 0;
   int          failures = 0;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge CLK40);
      #1;
   endtask

   function automatic exp_t obs_now();
      exp_t o;
      o = {HIT, HIT_IDX, MISS, WIN_EN};
      return o;
   endfunction

   function automatic exp_t model_decode(input logic [19:0] addr);
      exp_t       e;
      logic [3:0] lock_v;
      lock_v = LOCK;
      e = '0;
      e.miss = 1'b1;
      for (int i = 0; i < NWIN; i++) begin
         if (m_valid[i] && (((addr ^ m_base[i]) & m_mask[i]) == 20'h0)) begin
            e.hit    = 4'b0001 << i;
            e.idx    = 3'(i);
            e.miss   = 1'b0;
            e.win_en = (!lock_v[i] || m_unlock[i]) ? e.hit : 4'b0000;
            break;
         end
      end
      return e;
   endfunction

   task automatic model_clear(input bit all);
      for (int i = 0; i < NWIN; i++) begin
         m_valid[i]  = 1'b0;
         m_unlock[i] = 1'b0;
         if (all) begin
            m_base[i] = '0;
            m_mask[i] = '0;
         end
      end
   endtask

   task automatic cfg_write(input logic [2:0] idx, input logic [19:0] base, input logic [19:0] mask);
      CFG_WE = 1'b1; CFG_IDX = idx; CFG_BASE = base; CFG_MASK = mask;
      tick();
      CFG_WE = 1'b0;
      if (int'(idx) < NWIN) begin
         m_base[idx]  = base;
         m_mask[idx]  = mask;
         m_valid[idx] = 1'b1;
      end
   endtask

   task automatic cfg_clr();
      CFG_CLR = 1'b1;
      tick();
      CFG_CLR = 1'b0;
      model_clear(1'b0);
   endtask

   // Issue TS, push the model's decode, then pop and compare once the DUT is ACTIVE.
   task automatic start_cycle(input logic [19:0] addr, input logic rnw, input string name,
                              output exp_t cur);
      exp_t e, got;
      e = model_decode(addr);
      if (!rnw && !e.miss) m_unlock[e.idx] = 1'b1;
      sb.push_back(e);
      A = addr; RnW = rnw; TS = 1'b1;
      tick();
      TS = 1'b0;
      checks++;
      if (BUSY !== 1'b1 || obs_now() !== 12'h0) begin
         failures++;
         $display("FAIL %s_decode_phase: BUSY=%b outs=%h required BUSY=1 outs=000", name, BUSY, obs_now());
      end
      tick();
      got = obs_now();
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $display("FAIL %s_scoreboard: queue empty", name);
         cur = got;
      end else begin
         e = sb.pop_front();
         cur = e;
         if (got !== e) begin
            failures++;
            $display("FAIL %s: HIT=%b IDX=%0d MISS=%b WIN_EN=%b required HIT=%b IDX=%0d MISS=%b WIN_EN=%b",
                     name, got.hit, got.idx, got.miss, got.win_en, e.hit, e.idx, e.miss, e.win_en);
         end
      end
   endtask

   task automatic end_cycle(input string name);
      TERM = 1'b1;
      tick();
      TERM = 1'b0;
      checks++;
      if (obs_now() !== 12'h0 || BUSY !== 1'b0 || BERR !== 1'b0) begin
         failures++;
         $display("FAIL %s_term: outs=%h BUSY=%b BERR=%b required outs=000 BUSY=0 BERR=0",
                  name, obs_now(), BUSY, BERR);
      end
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      repeat (3) tick();
      checks++;
      if (obs_now() !== 12'h0 || BUSY !== 1'b0 || BERR !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: outs=%h BUSY=%b BERR=%b required all 0", obs_now(), BUSY, BERR);
      end
      RESET = 1'b0;
      model_clear(1'b1);
      tick();
   endtask

   task automatic test_basic_hit();
      exp_t cur;
      cfg_write(3'd1, 20'h00E90, 20'hFFFF0);
      start_cycle(20'h00E95, 1'b1, "basic_hit", cur);
      end_cycle("basic_hit");
   endtask

   task automatic test_overlap();
      exp_t cur;
      cfg_write(3'd0, 20'h00E00, 20'hFFF00);
      cfg_write(3'd2, 20'h00E80, 20'hFFFF0);
      start_cycle(20'h00E85, 1'b1, "overlap_prio", cur);
      end_cycle("overlap_prio");
      start_cycle(20'h00F85, 1'b1, "overlap_miss", cur);
      end_cycle("overlap_miss");
   endtask

   task automatic test_lock();
      exp_t cur;
      cfg_clr();
      cfg_write(3'd0, 20'h12340, 20'hFFFF0);
      start_cycle(20'h12345, 1'b1, "lock_read_locked", cur);
      end_cycle("lock_read_locked");
      start_cycle(20'h12346, 1'b0, "lock_unlocking_write", cur);
      end_cycle("lock_unlocking_write");
      start_cycle(20'h12345, 1'b1, "lock_read_unlocked", cur);
      end_cycle("lock_read_unlocked");
      cfg_clr();
      start_cycle(20'h12345, 1'b1, "lock_after_clr_miss", cur);
      end_cycle("lock_after_clr_miss");
      cfg_write(3'd0, 20'h12340, 20'hFFFF0);
      start_cycle(20'h12345, 1'b1, "lock_relocked", cur);
      end_cycle("lock_relocked");
   endtask

   task automatic test_ignored_idx();
      exp_t cur;
      cfg_write(3'd5, 20'h55550, 20'hFFFFF);
      start_cycle(20'h55550, 1'b1, "idx_out_of_range", cur);
      end_cycle("idx_out_of_range");
   endtask

   task automatic test_back_to_back();
      exp_t cur;
      cfg_write(3'd3, 20'hABC00, 20'hFFF00);
      start_cycle(20'hABC12, 1'b1, "b2b_read_w3", cur);
      end_cycle("b2b_1");
      start_cycle(20'hABC34, 1'b0, "b2b_write_w3", cur);
      end_cycle("b2b_2");
      start_cycle(20'h12345, 1'b0, "b2b_write_w0", cur);
      end_cycle("b2b_3");
      start_cycle(20'h12345, 1'b1, "b2b_read_w0", cur);
      end_cycle("b2b_4");
   endtask

   task automatic test_term_in_decode();
      A = 20'hABC00; RnW = 1'b1; TS = 1'b1;
      tick();
      TS = 1'b0; TERM = 1'b1;
      tick();
      TERM = 1'b0;
      checks++;
      if (BUSY !== 1'b0 || obs_now() !== 12'h0) begin
         failures++;
         $display("FAIL term_in_decode: BUSY=%b outs=%h required BUSY=0 outs=000", BUSY, obs_now());
      end
      tick();
      checks++;
      if (BUSY !== 1'b0 || obs_now() !== 12'h0) begin
         failures++;
         $display("FAIL term_in_decode_after: BUSY=%b outs=%h required BUSY=0 outs=000", BUSY, obs_now());
      end
   endtask

   task automatic test_ts_in_active();
      exp_t cur;
      start_cycle(20'hABC10, 1'b1, "ts_in_active", cur);
      A = 20'h00E95; TS = 1'b1;
      tick();
      TS = 1'b0;
      tick();
      checks++;
      if (obs_now() !== cur || BUSY !== 1'b1) begin
         failures++;
         $display("FAIL ts_in_active_hold: outs=%h BUSY=%b required outs=%h BUSY=1", obs_now(), BUSY, cur);
      end
      end_cycle("ts_in_active");
      tick();
      checks++;
      if (BUSY !== 1'b0) begin
         failures++;
         $display("FAIL ts_in_active_ignored: BUSY=%b required 0", BUSY);
      end
   endtask

   task automatic test_cfg_in_active();
      exp_t cur;
      start_cycle(20'hABC20, 1'b1, "cfg_in_active", cur);
      cfg_write(3'd3, 20'h77700, 20'hFFF00);
      tick();
      checks++;
      if (obs_now() !== cur) begin
         failures++;
         $display("FAIL cfg_in_active_hold: outs=%h required %h", obs_now(), cur);
      end
      end_cycle("cfg_in_active");
      start_cycle(20'hABC20, 1'b1, "cfg_old_addr", cur);
      end_cycle("cfg_old_addr");
      start_cycle(20'h77712, 1'b1, "cfg_new_addr", cur);
      end_cycle("cfg_new_addr");
   endtask

   task automatic test_watchdog();
      exp_t cur;
      start_cycle(20'h99999, 1'b1, "wd_miss", cur);
`ifdef DECODE_TIMEOUT_EN
      begin
         int n;
         n = 0;
         for (int k = 1; k <= 50; k++) begin
            tick();
            n = k;
            if (BUSY === 1'b0) break;
         end
         checks++;
         if (n != TIMEOUT || BERR !== 1'b1 || obs_now() !== 12'h0) begin
            failures++;
            $display("FAIL wd_expiry: cycles=%0d BERR=%b outs=%h required cycles=%0d BERR=1 outs=000",
                     n, BERR, obs_now(), TIMEOUT);
         end
         if (BUSY !== 1'b0) end_cycle("wd_recover");
         tick();
         checks++;
         if (BERR !== 1'b0) begin
            failures++;
            $display("FAIL wd_berr_pulse: BERR=%b required 0", BERR);
         end
      end
`else
      repeat (3 * TIMEOUT) tick();
      checks++;
      if (BUSY !== 1'b1 || MISS !== 1'b1 || BERR !== 1'b0) begin
         failures++;
         $display("FAIL wd_disabled_wait: BUSY=%b MISS=%b BERR=%b required BUSY=1 MISS=1 BERR=0",
                  BUSY, MISS, BERR);
      end
      end_cycle("wd_disabled");
`endif
   endtask

   task automatic test_reset_in_active();
      exp_t cur;
      start_cycle(20'h77701, 1'b1, "rst_in_active", cur);
      RESET = 1'b1;
      tick();
      checks++;
      if (obs_now() !== 12'h0 || BUSY !== 1'b0 || BERR !== 1'b0) begin
         failures++;
         $display("FAIL rst_in_active: outs=%h BUSY=%b BERR=%b required all 0", obs_now(), BUSY, BERR);
      end
      RESET = 1'b0;
      model_clear(1'b1);
      tick();
      start_cycle(20'h77701, 1'b1, "rst_windows_cleared", cur);
      end_cycle("rst_windows_cleared");
      cfg_write(3'd1, 20'h00E90, 20'hFFFF0);
      start_cycle(20'h00E95, 1'b1, "rst_reprogram", cur);
      end_cycle("rst_reprogram");
   endtask

   initial begin
      test_reset();
      test_basic_hit();
      test_overlap();
      test_lock();
      test_ignored_idx();
      test_back_to_back();
      test_term_in_decode();
      test_ts_in_active();
      test_cfg_in_active();
      test_watchdog();
      test_reset_in_active();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/u409_window_decode.md
# u409_window_decode

Parametrised, registered successor to the U409 fixed-map decoder. It provides `NWIN` programmable address windows, each defined by a base/mask pair loaded by the AUTOCONFIG logic. Each bus cycle is captured on transfer start and its decode is held stable until termination. Lockable windows implement the "ROM until first write" unlock generically, and an optional watchdog terminates unclaimed cycles with a bus error. It sits beside the fixed Z2 decode in U409 and drives chip enables for AUTOCONFIG'd on-board devices (ATA, bridge registers, future peripherals).

## Interface
- `NWIN`, 4: number of windows, 1–8.
- `ABITS`, 20: compared address bits; port `A` carries A[31:32-ABITS].
- `LOCK_MASK`, 4'b0001: bit i set makes window i lockable, meaning it is locked until its first write.
- `TIMEOUT`, 255: watchdog limit in CLK40 cycles, 1–255.

Ports:
- `CLK40`  in  1  system clock.
- `RESET`  in  1  synchronous, active-high reset.
- `TS`  in  1  transfer start, one-cycle pulse, active high.
- `TERM`  in  1  cycle termination (TA or TEA seen), active high.
- `A`  in  ABITS  address.
- `RnW`  in  1  1 = read.
- `CFG_WE`  in  1  write window registers.
- `CFG_IDX`  in  3  window index for the write.
- `CFG_BASE`  in  ABITS  base value.
- `CFG_MASK`  in  ABITS  compare mask; 1 = bit compared.
- `CFG_CLR`  in  1  invalidate all windows and relock; one cycle.
- `HIT`  out  NWIN  one-hot registered window hit.
- `HIT_IDX`  out  3  index of the hit window.
- `MISS`  out  1  cycle decoded, no window hit.
- `WIN_EN`  out  NWIN  HIT gated by unlock state, for chip enables.
- `BUSY`  out  1  state ≠ IDLE.
- `BERR`  out  1  watchdog bus-error pulse.

## Operation
- Window registers per window i: `BASE[i]`, `MASK[i]`, `VALID[i]`, `UNLOCK[i]`.
  - `CFG_WE` writes BASE/MASK of window `CFG_IDX` and sets VALID.
  - `CFG_IDX` ≥ NWIN is ignored.
  - `CFG_CLR` clears all VALID and UNLOCK bits and wins over a same-cycle `CFG_WE`.
- Match rule: window i matches when `VALID[i]` and `((A_lat ^ BASE[i]) & MASK[i]) == 0`.
  - When windows overlap, the lowest index wins. HIT stays one-hot.
- State machine (IDLE, DECODE, ACTIVE):
  - IDLE → DECODE on TS. A and RnW are latched on that edge.
  - DECODE → ACTIVE after exactly 1 cycle. HIT, HIT_IDX, MISS and WIN_EN are registered on this transition.
  - ACTIVE → IDLE on TERM, or on watchdog expiry.
  - TERM in DECODE → IDLE; outputs never assert for that cycle.
- Outputs are held constant throughout ACTIVE and clear on the edge that leaves ACTIVE.
- `WIN_EN[i] = HIT[i] && (!LOCK_MASK[i] || UNLOCK[i])`.
  - UNLOCK is sampled before update, so the unlocking write itself sees the window locked.
  - `UNLOCK[i]` sets on the DECODE→ACTIVE edge of a write cycle (RnW = 0) that hits window i. It is sticky until reset or CFG_CLR.
- Ignored inputs:
  - TS outside IDLE is ignored.
  - TERM in IDLE is ignored.
  - A CFG write during DECODE/ACTIVE does not alter the latched decode; it applies from the next TS.
- `MISS` = 1 when no window matches. A MISS cycle still waits for TERM or the watchdog.

## Timing
- Reset values: HIT = 0, HIT_IDX = 0, MISS = 0, WIN_EN = 0, BUSY = 0, BERR = 0, state IDLE, all VALID/UNLOCK = 0, BASE/MASK = 0.
  - RESET mid-cycle aborts to IDLE on the next edge; no BERR is issued.
- Decode latency: HIT is valid 2 edges after the TS edge (TS edge → DECODE, next edge → ACTIVE with outputs).
- Termination: outputs drop on the edge that samples TERM in ACTIVE. TS may be accepted on the following edge, giving a minimum back-to-back period of 3 cycles.
- BUSY is high from the edge after TS until the edge that leaves ACTIVE.

## Configuration
- `DECODE_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to ACTIVE and increments each ACTIVE cycle without TERM.
  - On reaching TIMEOUT, BERR pulses high for 1 cycle and the state returns to IDLE, clearing outputs.
  - TERM on the expiry cycle wins: no BERR.
- `DECODE_TIMEOUT_EN` undefined: no counter, BERR tied 0, and ACTIVE waits indefinitely for TERM.

## Test plan
- Basic hit: program win1 BASE = 20'h00E90, MASK = 20'hFFFF0; TS with A = 20'h00E95, RnW = 1 → HIT = 4'b0010, HIT_IDX = 1, MISS = 0, two edges after TS; TERM → all outputs clear on the next edge.
- Overlap priority: win0 and win2 both match A → HIT = 4'b0001, HIT_IDX = 0.
- Lock: win0 locked. Read hit → WIN_EN = 0. Write hit → WIN_EN = 0. Next read → WIN_EN = 4'b0001. CFG_CLR → relocked and VALID = 0.
- Miss/watchdog (macro on, TIMEOUT = 8): TS to an unmapped A, no TERM → MISS = 1, BERR high for 1 cycle on the 8th ACTIVE cycle, BUSY falls. Macro off: BUSY stays high until TERM.
- Boundaries: TS during ACTIVE is ignored. CFG_WE to the hit window during ACTIVE leaves HIT unchanged. RESET during ACTIVE → all outputs 0 on the next edge, with BERR = 0.
